// File: rtl/riscv_mem_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mem_pkg
//   Shared definitions for the unified instruction/data memory arbiter:
//   FSM state encoding, access-owner encoding and default bus widths.
// -----------------------------------------------------------------------------
package riscv_mem_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Which requester owns the access currently in flight
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//   Shares one unified instruction/data memory between the fetch port (IF)
//   and the data port (MEM stage). One access at a time: IDLE arbitrates,
//   ISSUE strobes the memory, WAIT counts out the read latency, RESP returns
//   the read data. Data port has priority; a saturating starvation counter
//   forces a fetch win after STARVE_MAX consecutive fetch losses.
//
// Ports
//   clk1, rst                 clock, synchronous active-high reset
//   halt                      blocks new grants; in-flight access completes
//   if_req/if_addr            fetch read request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata fetch grant pulse, read-valid pulse, data
//   dm_req/dm_we/dm_addr/
//   dm_wdata                  data request (load or store, held until dm_gnt)
//   dm_gnt/dm_rvalid/dm_rdata data grant pulse, load-valid pulse, data
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata       memory interface; rdata valid MEM_LAT after en
// All outputs are registered.
// -----------------------------------------------------------------------------
module unified_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'(MEM_LAT);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(1);
  localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_MAX);

  state_e            state_r, state_nxt_s;
  owner_e            owner_r, owner_nxt_s;
  logic [LAT_W-1:0]  lat_cnt_r, lat_cnt_nxt_s;
  logic [STV_W-1:0]  starve_r, starve_nxt_s;
  logic              pick_dm_s;
  logic              mem_en_nxt_s, mem_we_nxt_s;
  logic [ADDR_W-1:0] mem_addr_nxt_s;
  logic [DATA_W-1:0] mem_wdata_nxt_s;
  logic              if_gnt_nxt_s, dm_gnt_nxt_s;
  logic              if_rvalid_nxt_s, dm_rvalid_nxt_s;
  logic [DATA_W-1:0] if_rdata_nxt_s, dm_rdata_nxt_s;

  // Arbitration: data wins unless absent or fetch has lost STARVE_MAX times
  always_comb begin
    pick_dm_s = 1'b0;
    if (dm_req && !if_req) begin
      pick_dm_s = 1'b1;
    end else if (dm_req && if_req && (starve_r < STV_LIMIT)) begin
      pick_dm_s = 1'b1;
    end else begin
      pick_dm_s = 1'b0;
    end
  end

  // Next-state and next-output logic; outputs pulse by defaulting to zero
  always_comb begin
    state_nxt_s     = state_r;
    owner_nxt_s     = owner_r;
    lat_cnt_nxt_s   = lat_cnt_r;
    starve_nxt_s    = starve_r;
    mem_en_nxt_s    = 1'b0;
    mem_we_nxt_s    = 1'b0;
    mem_addr_nxt_s  = mem_addr;
    mem_wdata_nxt_s = mem_wdata;
    if_gnt_nxt_s    = 1'b0;
    dm_gnt_nxt_s    = 1'b0;
    if_rvalid_nxt_s = 1'b0;
    dm_rvalid_nxt_s = 1'b0;
    if_rdata_nxt_s  = if_rdata;
    dm_rdata_nxt_s  = dm_rdata;
    case (state_r)
      ST_IDLE: begin
        if (!halt && (if_req || dm_req)) begin
          state_nxt_s  = ST_ISSUE;
          mem_en_nxt_s = 1'b1;
          if (pick_dm_s) begin
            owner_nxt_s     = OWN_DM;
            dm_gnt_nxt_s    = 1'b1;
            mem_addr_nxt_s  = dm_addr;
            mem_we_nxt_s    = dm_we;
            mem_wdata_nxt_s = dm_wdata;
            // Only a contested loss counts against fetch; never wraps
            if (if_req && (starve_r != STV_LIMIT)) begin
              starve_nxt_s = starve_r + STV_W'(1);
            end else begin
              starve_nxt_s = starve_r;
            end
          end else begin
            owner_nxt_s     = OWN_IF;
            if_gnt_nxt_s    = 1'b1;
            mem_addr_nxt_s  = if_addr;
            mem_we_nxt_s    = 1'b0;
            mem_wdata_nxt_s = '0;
            starve_nxt_s    = '0;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Requests are not looked at here, so a held req cannot re-issue
        if (mem_we) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s   = ST_WAIT;
          lat_cnt_nxt_s = LAT_LOAD;
        end
      end
      ST_WAIT: begin
        if (lat_cnt_r == LAT_LAST) begin
          state_nxt_s = ST_RESP;
          if (owner_r == OWN_DM) begin
            dm_rdata_nxt_s  = mem_rdata;
            dm_rvalid_nxt_s = 1'b1;
          end else begin
            if_rdata_nxt_s  = mem_rdata;
            if_rvalid_nxt_s = 1'b1;
          end
        end else begin
          lat_cnt_nxt_s = lat_cnt_r - LAT_W'(1);
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset discards any in-flight read
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      owner_r   <= OWN_IF;
      lat_cnt_r <= '0;
      starve_r  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      state_r   <= state_nxt_s;
      owner_r   <= owner_nxt_s;
      lat_cnt_r <= lat_cnt_nxt_s;
      starve_r  <= starve_nxt_s;
      mem_en    <= mem_en_nxt_s;
      mem_we    <= mem_we_nxt_s;
      mem_addr  <= mem_addr_nxt_s;
      mem_wdata <= mem_wdata_nxt_s;
      if_gnt    <= if_gnt_nxt_s;
      dm_gnt    <= dm_gnt_nxt_s;
      if_rvalid <= if_rvalid_nxt_s;
      dm_rvalid <= dm_rvalid_nxt_s;
      if_rdata  <= if_rdata_nxt_s;
      dm_rdata  <= dm_rdata_nxt_s;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_unified_mem_arbiter
//   Two arbiters: u_dut1 (MEM_LAT=1) and u_dut3 (MEM_LAT=3), each with its own
//   behavioural memory. Expected read data comes from the bench reference
//   array and is queued per port; a negedge monitor pops and compares on
//   every rvalid.
// -----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

  logic        clk1 = 1'b0;
  logic        rst, halt, tb_init;
  logic        if_req, dm_req, dm_we, if_req3;
  logic [9:0]  if_addr, dm_addr;
  logic [31:0] dm_wdata;

  logic        if_gnt1, if_rvalid1, dm_gnt1, dm_rvalid1, mem_en1, mem_we1;
  logic [31:0] if_rdata1, dm_rdata1, mem_wdata1, mem_rdata1;
  logic [9:0]  mem_addr1;
  logic        if_gnt3, if_rvalid3, dm_gnt3, dm_rvalid3, mem_en3, mem_we3;
  logic [31:0] if_rdata3, dm_rdata3, mem_wdata3, mem_rdata3;
  logic [9:0]  mem_addr3;

  logic [31:0] mem1 [1024];
  logic [31:0] mem3 [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] pipe1, pipe3_0, pipe3_1, pipe3_2;

  logic [31:0] q_if [$];
  logic [31:0] q_dm [$];
  logic [31:0] q_if3 [$];

  int total = 0;
  int bad   = 0;

  always #5 clk1 = ~clk1;

  unified_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk1(clk1), .rst(rst), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt1), .dm_rvalid(dm_rvalid1), .dm_rdata(dm_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1)
  );

  unified_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk1(clk1), .rst(rst), .halt(halt),
    .if_req(if_req3), .if_addr(if_addr), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt3), .dm_rvalid(dm_rvalid3), .dm_rdata(dm_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3)
  );

  function automatic logic [31:0] pattern(input int a);
    if (a == 5) return 32'h280a00c8;
    else return 32'ha5a50000 ^ 32'(a);
  endfunction

  // Behavioural memories: synchronous write, read data MEM_LAT cycles after en
  always @(posedge clk1) begin
    if (tb_init) begin
      for (int i = 0; i < 1024; i++) begin
        mem1[i] <= pattern(i);
        mem3[i] <= pattern(i);
      end
    end else begin
      if (mem_en1 && mem_we1) mem1[mem_addr1] <= mem_wdata1;
      if (mem_en3 && mem_we3) mem3[mem_addr3] <= mem_wdata3;
    end
    pipe1   <= (mem_en1 && !mem_we1) ? mem1[mem_addr1] : 32'hdeadbeef;
    pipe3_0 <= (mem_en3 && !mem_we3) ? mem3[mem_addr3] : 32'hdeadbeef;
    pipe3_1 <= pipe3_0;
    pipe3_2 <= pipe3_1;
  end
  assign mem_rdata1 = pipe1;
  assign mem_rdata3 = pipe3_2;

  // Scoreboard monitor: every rvalid must match the oldest queued expectation
  always @(negedge clk1) begin
    logic [31:0] e;
    if (if_rvalid1 === 1'b1) begin
      total++;
      if (q_if.size() == 0) begin
        bad++; $display("FAIL sb_if1: unexpected if_rvalid, rdata=%h", if_rdata1);
      end else begin
        e = q_if.pop_front();
        if (if_rdata1 !== e) begin bad++; $display("FAIL sb_if1: got %h want %h", if_rdata1, e); end
      end
    end
    if (dm_rvalid1 === 1'b1) begin
      total++;
      if (q_dm.size() == 0) begin
        bad++; $display("FAIL sb_dm1: unexpected dm_rvalid, rdata=%h", dm_rdata1);
      end else begin
        e = q_dm.pop_front();
        if (dm_rdata1 !== e) begin bad++; $display("FAIL sb_dm1: got %h want %h", dm_rdata1, e); end
      end
    end
    if (if_rvalid3 === 1'b1) begin
      total++;
      if (q_if3.size() == 0) begin
        bad++; $display("FAIL sb_if3: unexpected if_rvalid, rdata=%h", if_rdata3);
      end else begin
        e = q_if3.pop_front();
        if (if_rdata3 !== e) begin bad++; $display("FAIL sb_if3: got %h want %h", if_rdata3, e); end
      end
    end
    if (mem_we1 === 1'b1 && mem_en1 !== 1'b1) begin
      total++; bad++; $display("FAIL we_outside_issue: mem_we=1 mem_en=%b want mem_en=1", mem_en1);
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk1); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    total++;
    if ({if_gnt1, if_rvalid1, if_rdata1, dm_gnt1, dm_rvalid1, dm_rdata1, mem_en1, mem_we1, mem_addr1, mem_wdata1} !== '0) begin
      bad++; $display("FAIL reset_dut1: outputs gnt=%b/%b en=%b we=%b addr=%h want all 0", if_gnt1, dm_gnt1, mem_en1, mem_we1, mem_addr1);
    end
    total++;
    if ({if_gnt3, if_rvalid3, if_rdata3, dm_gnt3, dm_rvalid3, dm_rdata3, mem_en3, mem_we3, mem_addr3, mem_wdata3} !== '0) begin
      bad++; $display("FAIL reset_dut3: outputs gnt=%b en=%b addr=%h want all 0", if_gnt3, mem_en3, mem_addr3);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_lone_fetch();
    if_addr = 10'd5; if_req = 1'b1;
    q_if.push_back(ref_mem[5]);
    tick(1);
    total++;
    if ({if_gnt1, dm_gnt1, mem_en1, mem_we1, mem_addr1} !== {1'b1, 1'b0, 1'b1, 1'b0, 10'd5}) begin
      bad++; $display("FAIL fetch_issue: if_gnt=%b dm_gnt=%b en=%b we=%b addr=%0d want 1 0 1 0 5", if_gnt1, dm_gnt1, mem_en1, mem_we1, mem_addr1);
    end
    if_req = 1'b0;
    tick(1);
    total++;
    if (if_rvalid1 !== 1'b0 || mem_en1 !== 1'b0) begin
      bad++; $display("FAIL fetch_wait: rvalid=%b en=%b want 0 0", if_rvalid1, mem_en1);
    end
    tick(1);
    total++;
    if (if_rvalid1 !== 1'b1 || if_rdata1 !== 32'h280a00c8) begin
      bad++; $display("FAIL fetch_resp: rvalid=%b rdata=%h want 1 280a00c8", if_rvalid1, if_rdata1);
    end
    tick(2);
  endtask

  task automatic test_store_load();
    dm_addr = 10'd200; dm_wdata = 32'd4; dm_we = 1'b1; dm_req = 1'b1;
    ref_mem[200] = 32'd4;
    tick(1);
    total++;
    if ({dm_gnt1, mem_en1, mem_we1, mem_addr1, mem_wdata1} !== {1'b1, 1'b1, 1'b1, 10'd200, 32'd4}) begin
      bad++; $display("FAIL store_issue: gnt=%b en=%b we=%b addr=%0d wdata=%h want 1 1 1 200 4", dm_gnt1, mem_en1, mem_we1, mem_addr1, mem_wdata1);
    end
    dm_req = 1'b0; dm_we = 1'b0;
    tick(1);
    total++;
    if (mem_we1 !== 1'b0 || mem_en1 !== 1'b0 || dm_rvalid1 !== 1'b0) begin
      bad++; $display("FAIL store_done: we=%b en=%b rvalid=%b want 0 0 0", mem_we1, mem_en1, dm_rvalid1);
    end
    dm_req = 1'b1;
    q_dm.push_back(ref_mem[200]);
    tick(1);
    total++;
    if (dm_gnt1 !== 1'b1 || mem_we1 !== 1'b0) begin
      bad++; $display("FAIL load_issue: gnt=%b we=%b want 1 0", dm_gnt1, mem_we1);
    end
    dm_req = 1'b0;
    tick(2);
    total++;
    if (dm_rvalid1 !== 1'b1 || dm_rdata1 !== 32'd4) begin
      bad++; $display("FAIL load_resp: rvalid=%b rdata=%h want 1 4", dm_rvalid1, dm_rdata1);
    end
    tick(2);
  endtask

  task automatic test_contention();
    bit got_dm, want_dm;
    int wait_n;
    if_addr = 10'd5; dm_addr = 10'd200; dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_n = 0;
      tick(1);
      while (!(if_gnt1 || dm_gnt1) && wait_n < 10) begin
        tick(1); wait_n++;
      end
      want_dm = (k % 5) != 4;
      total++;
      if (!(if_gnt1 || dm_gnt1)) begin
        bad++; $display("FAIL contention_timeout: grant %0d never seen", k);
      end else begin
        got_dm = dm_gnt1;
        if (got_dm) q_dm.push_back(ref_mem[200]);
        else        q_if.push_back(ref_mem[5]);
        if (got_dm !== want_dm || (if_gnt1 && dm_gnt1)) begin
          bad++; $display("FAIL contention_order: grant %0d dm=%b if=%b want dm=%b", k, dm_gnt1, if_gnt1, want_dm);
        end
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick(4);
  endtask

  task automatic test_halt();
    dm_addr = 10'd200; dm_we = 1'b0; dm_req = 1'b1;
    q_dm.push_back(ref_mem[200]);
    tick(1);
    total++;
    if (dm_gnt1 !== 1'b1) begin bad++; $display("FAIL halt_load_gnt: got %b want 1", dm_gnt1); end
    dm_req = 1'b0; if_addr = 10'd5; if_req = 1'b1;
    tick(1);
    halt = 1'b1;
    tick(1);
    total++;
    if (dm_rvalid1 !== 1'b1) begin bad++; $display("FAIL halt_rvalid: got %b want 1", dm_rvalid1); end
    for (int i = 0; i < 4; i++) begin
      tick(1);
      total++;
      if (if_gnt1 !== 1'b0 || dm_gnt1 !== 1'b0 || mem_en1 !== 1'b0) begin
        bad++; $display("FAIL halt_block: cycle %0d if_gnt=%b dm_gnt=%b en=%b want 0 0 0", i, if_gnt1, dm_gnt1, mem_en1);
      end
    end
    halt = 1'b0;
    q_if.push_back(ref_mem[5]);
    tick(1);
    total++;
    if (if_gnt1 !== 1'b1 || mem_en1 !== 1'b1) begin
      bad++; $display("FAIL halt_release: if_gnt=%b en=%b want 1 1", if_gnt1, mem_en1);
    end
    if_req = 1'b0;
    tick(4);
  endtask

  task automatic test_reset_mid_read();
    if_addr = 10'd5; if_req = 1'b1;
    tick(1);
    total++;
    if (if_gnt1 !== 1'b1) begin bad++; $display("FAIL rstmid_gnt: got %b want 1", if_gnt1); end
    if_req = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    total++;
    if ({if_gnt1, if_rvalid1, if_rdata1, dm_gnt1, dm_rvalid1, dm_rdata1, mem_en1, mem_we1, mem_addr1, mem_wdata1} !== '0) begin
      bad++; $display("FAIL rstmid_outputs: rvalid=%b rdata=%h addr=%h want all 0", if_rvalid1, if_rdata1, mem_addr1);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      total++;
      if (if_rvalid1 !== 1'b0) begin bad++; $display("FAIL rstmid_no_rvalid: cycle %0d rvalid=%b want 0", i, if_rvalid1); end
    end
  endtask

  task automatic test_held_request();
    int en_cnt = 0;
    if_addr = 10'd5; if_req3 = 1'b1;
    q_if3.push_back(ref_mem[5]);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (k == 1) begin
        total++;
        if (if_gnt3 !== 1'b1) begin bad++; $display("FAIL held_gnt: got %b want 1", if_gnt3); end
      end
      if (mem_en3 === 1'b1) en_cnt++;
      total++;
      if (if_rvalid3 !== (k == 5)) begin
        bad++; $display("FAIL held_rvalid_time: t+%0d rvalid=%b want %b", k, if_rvalid3, (k == 5));
      end
      if (k == 2) if_req3 = 1'b0;
    end
    total++;
    if (en_cnt != 1) begin bad++; $display("FAIL held_single_issue: mem_en count %0d want 1", en_cnt); end
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; tb_init = 1'b1;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; if_req3 = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pattern(i);
    tick(1);
    tb_init = 1'b0;
    test_reset();
    test_lone_fetch();
    test_store_load();
    test_contention();
    test_halt();
    test_reset_mid_read();
    test_held_request();
    tick(2);
    total++;
    if (q_if.size() != 0 || q_dm.size() != 0 || q_if3.size() != 0) begin
      bad++; $display("FAIL sb_drain: pending if=%0d dm=%0d if3=%0d want 0 0 0", q_if.size(), q_dm.size(), q_if3.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
